instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Front-end fetch stage directly upstream of the instruction queue. Holds the PC and issues one 64-bit aligned fetch at a time to instruction memory over a req/gnt/rvalid handshake. Splits each returned block into an `inst0`/`inst1` pair and hands the pair to the queue with a valid/ready handshake. Detects misaligned PCs without touching memory, and flushes the queue on redirect.

## Interface
- `XLEN`, 64: datapath width; instructions are `XLEN/2` bits.
- `ADDR_WIDTH`, 64: PC/address width.
- `RESET_PC`, 64'h0000_0000_8000_0000: PC loaded on reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `redirect_valid_i` in 1: branch/exception redirect request.
- `redirect_pc_i` in ADDR_WIDTH: redirect target.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out ADDR_WIDTH: fetch address, always `{pc[ADDR_WIDTH-1:3],3'b000}`.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: read data valid.
- `imem_rdata_i` in XLEN: 8-byte block; bits [31:0] are the lower address.
- `instr_queue_ready_i` in 1: queue can accept a pair.
- `inst0_o`, `inst1_o` out XLEN/2 each: instruction pair, in program order.
- `inst_valid_o` out 1: pair valid.
- `misaligned_exception_o` out 1: pair carries a misaligned-fetch exception.
- `misaligned_addr_o` out ADDR_WIDTH: faulting PC, valid with the exception.
- `ifu_flush_o` out 1: one-cycle queue flush pulse.

## Operation
- **States:** IDLE, REQ, WAIT, HOLD, DRAIN, HALT.
- **IDLE:** reset state; goes to REQ on the next cycle.
- **REQ:**
  - If `pc[1:0]!=0`: no request is issued. Load the output registers with `inst0/1=0`, `misaligned_exception_o=1`, `misaligned_addr_o=pc`, `inst_valid_o=1`, then go to HOLD. HOLD exits to HALT instead of REQ.
  - Otherwise drive `imem_req_o=1` until `imem_gnt_i`, then go to WAIT.
- **WAIT:** on `imem_rvalid_i`, load the outputs and go to HOLD.
  - `pc[2]=0`: `inst0=rdata[31:0]`, `inst1=rdata[63:32]`, next pc = pc+8.
  - `pc[2]=1`: `inst0=rdata[63:32]`, `inst1=NOP` (32'h0000_0013), next pc = pc+4.
- **HOLD:** `inst_valid_o=1` and all payload outputs stable until `inst_valid_o && instr_queue_ready_i`. On that transfer, clear `inst_valid_o` and go to REQ (or HALT after a misaligned pair).
- **HALT:** no fetch; waits for a redirect.
- **Redirect** (any state):
  - pc <= `redirect_pc_i`; `inst_valid_o` is cleared next cycle; `ifu_flush_o=1` for exactly the next cycle.
  - If a granted response is still outstanding, go to DRAIN. This covers: in WAIT without `imem_rvalid_i` the same cycle, or in REQ with `imem_gnt_i` the same cycle. Otherwise go to REQ.
- **DRAIN:** discards the next `imem_rvalid_i` (no output load), then goes to REQ. A redirect in DRAIN updates pc again and stays in DRAIN.
- **Simultaneous events:** redirect beats rvalid/transfer. A redirect in WAIT together with rvalid discards the data and goes to REQ. A redirect in HOLD together with ready drops the pair; it is not counted as transferred.
- **PC arithmetic:** modulo 2^ADDR_WIDTH; wrap-around is not an error.

## Timing
- **Reset values:** all outputs 0 except `imem_addr_o = RESET_PC & ~7`. pc=RESET_PC, state IDLE.
- **Request:** `imem_req_o` rises 2 cycles after reset release.
- **Latency:** `imem_rvalid_i` at cycle N → `inst_valid_o` at N+1. Transfer at cycle M → `imem_req_o` at M+1.
- **Outstanding requests:** at most one. Throughput is one pair per 3 cycles with zero-wait memory.
- **Output timing:** all outputs are registered except `imem_req_o` and `imem_addr_o`, which decode from state/pc.
- **Flush:** `ifu_flush_o` is high in the cycle after `redirect_valid_i`. `inst_valid_o` is low in that same cycle.

## Structure
- **Package `fetch_pkg`:** state enum, `NOP_INST` constant, fetch block size (8).
- **Sub-module `ifu_pc_gen`:** pc register plus next-pc mux (redirect / +4 / +8 / hold). Same clk/rst.
- **FSM, output registers, DRAIN logic:** live in the top module.

## Test plan
- **Reset:** reset release, zero-wait memory returning 64'h0000_0093_0000_0013 at 0x8000_0000 → `imem_req_o` on cycle 2. Then pair inst0=0x13, inst1=0x93 with `inst_valid_o`; next address 0x8000_0008.
- **Back-pressure:** `instr_queue_ready_i=0` for 5 cycles while HOLD → outputs stable, no new `imem_req_o`. Transfer on the first ready cycle.
- **Redirect while outstanding:** redirect to 0x8000_0104 in WAIT, rvalid 2 cycles later. Expect: stale data discarded, `ifu_flush_o` pulse, fetch at 0x8000_0100, pair inst0=rdata[63:32], inst1=0x13, next pc 0x8000_0108.
- **Misaligned target:** redirect to 0x8000_0002 → no `imem_req_o`; pair with `misaligned_exception_o=1`, `misaligned_addr_o=0x8000_0002`; HALT until the next redirect.
- **Same-cycle collisions:** redirect with `imem_gnt_i` in REQ, and separately redirect with rvalid in WAIT → exactly one discarded response, no spurious `inst_valid_o`.
- **Reset mid-operation:** assert `rst` in HOLD → outputs zero immediately (async); refetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the fetch FSM encoding, the filler NOP and the fetch block size.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } fetch_state_e;

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam int unsigned FETCH_BYTES = 8;

endpackage

// File: rtl/ifu_pc_gen.sv
// Program counter register with next-pc selection: redirect, +4, +8 or hold.
// Redirect has priority over sequential advance.
module ifu_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  adv_i,
  input  logic                  adv_full_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;

  always_comb begin
    w_pc_nxt = r_pc;
    if (redirect_valid_i) begin
      w_pc_nxt = redirect_pc_i;
    end else if (adv_i) begin
      // A block fetched from its upper word only yields one instruction.
      w_pc_nxt = adv_full_i ? r_pc + ADDR_WIDTH'(FETCH_BYTES)
                            : r_pc + ADDR_WIDTH'(FETCH_BYTES / 2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign pc_o = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding 64-bit fetch, splits the block into an instruction
// pair for the queue, flags misaligned PCs and flushes the queue on redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           XLEN       = 64,
  parameter int unsigned           ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [XLEN-1:0]       imem_rdata_i,
  input  logic                  instr_queue_ready_i,
  output logic [XLEN/2-1:0]     inst0_o,
  output logic [XLEN/2-1:0]     inst1_o,
  output logic                  inst_valid_o,
  output logic                  misaligned_exception_o,
  output logic [ADDR_WIDTH-1:0] misaligned_addr_o,
  output logic                  ifu_flush_o
);

  localparam int unsigned     IW    = XLEN / 2;
  localparam logic [IW-1:0]   L_NOP = IW'(NOP_INST);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_pc;
  logic                  w_misaligned;
  logic                  w_req;
  logic                  w_load_data;
  logic                  w_load_mis;
  logic                  w_xfer;
  logic                  w_adv;

  logic [IW-1:0]         r_inst0;
  logic [IW-1:0]         r_inst1;
  logic                  r_valid;
  logic                  r_exc;
  logic [ADDR_WIDTH-1:0] r_mis_addr;
  logic                  r_flush;
  logic                  r_halt_pend;

  ifu_pc_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_gen (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .adv_i            (w_adv),
    .adv_full_i       (~w_pc[2]),
    .pc_o             (w_pc)
  );

  assign w_misaligned = |w_pc[1:0];
  assign w_req        = (r_state == S_REQ) && !w_misaligned;
  assign imem_req_o   = w_req;
  assign imem_addr_o  = {w_pc[ADDR_WIDTH-1:3], 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_data = 1'b0;
    w_load_mis  = 1'b0;
    w_xfer      = 1'b0;
    w_adv       = 1'b0;
    unique case (r_state)
      S_IDLE:  w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_misaligned) begin
          w_load_mis  = 1'b1;
          w_state_nxt = S_HOLD;
        end else if (imem_gnt_i) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          w_load_data = 1'b1;
          w_adv       = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_valid && instr_queue_ready_i) begin
          w_xfer      = 1'b1;
          w_state_nxt = r_halt_pend ? S_HALT : S_REQ;
        end
      end
      S_DRAIN: if (imem_rvalid_i) w_state_nxt = S_REQ;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
    // Redirect wins over any same-cycle response or transfer; only a granted,
    // still-unreturned response needs draining.
    if (redirect_valid_i) begin
      w_load_data = 1'b0;
      w_load_mis  = 1'b0;
      w_xfer      = 1'b0;
      w_adv       = 1'b0;
      if (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_rvalid_i) begin
        w_state_nxt = S_DRAIN;
      end else if (w_req && imem_gnt_i) begin
        w_state_nxt = S_DRAIN;
      end else begin
        w_state_nxt = S_REQ;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst0     <= '0;
      r_inst1     <= '0;
      r_valid     <= 1'b0;
      r_exc       <= 1'b0;
      r_mis_addr  <= '0;
      r_flush     <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_flush <= redirect_valid_i;
      if (redirect_valid_i) begin
        r_valid <= 1'b0;
        r_exc   <= 1'b0;
      end else if (w_load_data) begin
        r_inst0     <= w_pc[2] ? imem_rdata_i[XLEN-1:IW] : imem_rdata_i[IW-1:0];
        r_inst1     <= w_pc[2] ? L_NOP : imem_rdata_i[XLEN-1:IW];
        r_valid     <= 1'b1;
        r_exc       <= 1'b0;
        r_halt_pend <= 1'b0;
      end else if (w_load_mis) begin
        r_inst0     <= '0;
        r_inst1     <= '0;
        r_valid     <= 1'b1;
        r_exc       <= 1'b1;
        r_mis_addr  <= w_pc;
        r_halt_pend <= 1'b1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign inst0_o                = r_inst0;
  assign inst1_o                = r_inst1;
  assign inst_valid_o           = r_valid;
  assign misaligned_exception_o = r_exc;
  assign misaligned_addr_o      = r_mis_addr;
  assign ifu_flush_o            = r_flush;

endmodule
